// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the main-memory port arbiter and its clients.
package cpu_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int LAT_W  = 4;

    localparam logic CPU_PORT = 1'b0;
    localparam logic DMA_PORT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_pick2
    import cpu_mem_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = CPU_PORT;
        if (req0_i && req1_i) begin
            winner_o = ~last_gnt_i;
        end else if (req1_i) begin
            winner_o = DMA_PORT;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between the CPU (port 0) and the DMA (port 1),
// one transaction at a time: IDLE -> ACCESS -> WAIT -> ACK, all outputs registered.
module mem_port_arbiter #(
    parameter int          ADDR_W  = cpu_mem_pkg::ADDR_W,
    parameter int          DATA_W  = cpu_mem_pkg::DATA_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic [1:0]        dbg_state
);

    import cpu_mem_pkg::*;

    arb_state_e        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              pick_valid, pick_winner;

    rr_pick2 u_pick (
        .req0_i     (req0),
        .req1_i     (req1),
        .last_gnt_i (last_gnt_q),
        .valid_o    (pick_valid),
        .winner_o   (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_WAIT;
            ST_WAIT:   if (cnt_q == '0) state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output; requests are only looked at in IDLE.
    always_comb begin
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d       = pick_winner;
                    last_gnt_d  = pick_winner;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (pick_winner == DMA_PORT) ? we1    : we0;
                    mem_addr_d  = (pick_winner == DMA_PORT) ? addr1  : addr0;
                    mem_wdata_d = (pick_winner == DMA_PORT) ? wdata1 : wdata0;
                end
            end
            ST_ACCESS: cnt_d = LAT_W'(MEM_LAT - 1);
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_q == DMA_PORT) begin
                        ack1_d   = 1'b1;
                        rdata1_d = mem_rdata;
                    end else begin
                        ack0_d   = 1'b1;
                        rdata0_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q  <= DMA_PORT;
            gnt_q       <= CPU_PORT;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign gnt_id    = gnt_q;
    assign dbg_state = state_q;

endmodule
